// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Purpose:
//   Turns the PLL lock indication into staged reset releases in the sys_clk
//   domain. The lock is synchronised and has to stay stable for a while before
//   the SDRAM controller leaves reset. The CPU and peripherals leave reset a
//   fixed delay after the SDRAM controller reports that its init is done.
//   Loss of lock puts the whole system back into reset and restarts the
//   sequence. An SDRAM init that never completes latches a sticky fault, and
//   only rst clears it.
//
// Ports:
//   sys_clk        in   1  system clock, rising edge
//   rst            in   1  synchronous, active-high reset
//   pll_locked     in   1  PLL lock, asynchronous to sys_clk
//   sdr_init_done  in   1  SDRAM controller init complete (level)
//   sdr_rst        out  1  active-high reset to the SDRAM controller
//   cpu_rst        out  1  active-high reset to CPU, PIT and peripherals
//   ready          out  1  high only in RUN
//   fault          out  1  sticky init-timeout flag
//   state          out  3  current FSM state (debug)
//
// Optional feature (macro PLL_RESET_SEQ_LOSS_CNT_EN):
//   loss_cnt       out  8  saturating count of lock-loss events
//   lock_lost      out  1  one-cycle pulse per counted lock-loss event
//
// All outputs are registered. They are decoded from the next state, so they
// change on the same edge as state.
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned CPU_DELAY     = 16,
  parameter int unsigned INIT_TIMEOUT  = 65535,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       sdr_init_done,
  output logic       sdr_rst,
  output logic       cpu_rst,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0] loss_cnt,
  output logic       lock_lost
`endif
);

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_SDR_INIT  = 3'd3,
    ST_CPU_DLY   = 3'd4,
    ST_RUN       = 3'd5,
    ST_FAULT     = 3'd6
  } state_t;

  // Terminal counter values. A counter starting at zero reaches N-1 on the
  // Nth cycle spent in a state, so each timed state lasts exactly N cycles.
  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CPU_LAST     = CNT_W'(CPU_DELAY - 32'd1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(INIT_TIMEOUT - 32'd1);

  // Elaboration-time sanity checks on the parameter set
  generate
    if (STABLE_CYCLES < 32'd2) begin : g_bad_stable
      $error("pll_reset_sequencer: STABLE_CYCLES must be >= 2");
    end
    if (CPU_DELAY < 32'd1) begin : g_bad_cpu_delay
      $error("pll_reset_sequencer: CPU_DELAY must be >= 1");
    end
    if (INIT_TIMEOUT < 32'd1) begin : g_bad_timeout
      $error("pll_reset_sequencer: INIT_TIMEOUT must be >= 1");
    end
    if ((64'(STABLE_CYCLES) > ((64'd1 << CNT_W) - 64'd1)) ||
        (64'(CPU_DELAY)     > ((64'd1 << CNT_W) - 64'd1)) ||
        (64'(INIT_TIMEOUT)  > ((64'd1 << CNT_W) - 64'd1))) begin : g_bad_cnt_w
      $error("pll_reset_sequencer: CNT_W too narrow for the configured delays");
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Lock synchroniser
  // ---------------------------------------------------------------------------
  logic sync_meta_q, sync_meta_d;
  logic lk_q, lk_d;
  logic lk_s;

  // Next-value logic for the two synchroniser stages
  always_comb begin
    sync_meta_d = pll_locked;
    lk_d        = sync_meta_q;
  end

  // Two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync_meta_q <= 1'b0;
      lk_q        <= 1'b0;
    end else begin
      sync_meta_q <= sync_meta_d;
      lk_q        <= lk_d;
    end
  end

  assign lk_s = lk_q;

  // ---------------------------------------------------------------------------
  // Sequencer FSM and shared cycle counter
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc_s;

  // Saturating increment. The counter must never wrap back to a terminal value.
  always_comb begin
    if (cnt_q == CNT_MAX) begin
      cnt_inc_s = cnt_q;
    end else begin
      cnt_inc_s = cnt_q + CNT_ONE;
    end
  end

  // Next-state and counter logic. Lock loss is tested first in every active
  // state so that it overrides any other transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_HOLD: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = CNT_ZERO;
      end
      ST_WAIT_LOCK: begin
        cnt_d = CNT_ZERO;
        if (lk_s) begin
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_SETTLE: begin
        if (!lk_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_SDR_INIT;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_SDR_INIT: begin
        // A done that arrives on the timeout cycle still counts as success
        if (!lk_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end else if (sdr_init_done) begin
          state_d = ST_CPU_DLY;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_CPU_DLY: begin
        if (!lk_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CPU_LAST) begin
          state_d = ST_RUN;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_RUN: begin
        if (!lk_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FAULT: begin
        // Terminal. Only rst leaves it, and lock activity is ignored.
        state_d = ST_FAULT;
      end
      default: begin
        // Unreachable encoding (7): recover through a full reset sequence
        state_d = ST_HOLD;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State register and shared counter
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= ST_HOLD;
      cnt_q   <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs decoded from the next state
  // ---------------------------------------------------------------------------
  logic sdr_rst_q, sdr_rst_d;
  logic cpu_rst_q, cpu_rst_d;
  logic ready_q, ready_d;
  logic fault_q, fault_d;

  // Output decode. Everything defaults to the safe (in-reset) value.
  always_comb begin
    sdr_rst_d = 1'b1;
    cpu_rst_d = 1'b1;
    ready_d   = 1'b0;
    fault_d   = 1'b0;
    case (state_d)
      ST_SDR_INIT: begin
        sdr_rst_d = 1'b0;
      end
      ST_CPU_DLY: begin
        sdr_rst_d = 1'b0;
      end
      ST_RUN: begin
        sdr_rst_d = 1'b0;
        cpu_rst_d = 1'b0;
        ready_d   = 1'b1;
      end
      ST_FAULT: begin
        fault_d = 1'b1;
      end
      default: begin
        sdr_rst_d = 1'b1;
        cpu_rst_d = 1'b1;
        ready_d   = 1'b0;
        fault_d   = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sdr_rst_q <= 1'b1;
      cpu_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      sdr_rst_q <= sdr_rst_d;
      cpu_rst_q <= cpu_rst_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  assign sdr_rst = sdr_rst_q;
  assign cpu_rst = cpu_rst_q;
  assign ready   = ready_q;
  assign fault   = fault_q;
  assign state   = state_q;

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
  // ---------------------------------------------------------------------------
  // Lock-loss statistics
  // ---------------------------------------------------------------------------
  logic       loss_evt_s;
  logic [7:0] loss_cnt_q, loss_cnt_d;
  logic       lock_lost_q, lock_lost_d;

  // A lock-loss event is the FSM leaving an active state because lk_s dropped
  always_comb begin
    if (!lk_s && ((state_q == ST_SETTLE) || (state_q == ST_SDR_INIT) ||
                  (state_q == ST_CPU_DLY) || (state_q == ST_RUN))) begin
      loss_evt_s = 1'b1;
    end else begin
      loss_evt_s = 1'b0;
    end
  end

  // Saturating event counter and single-cycle pulse
  always_comb begin
    lock_lost_d = loss_evt_s;
    if (loss_evt_s && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_d = loss_cnt_q + 8'd1;
    end else begin
      loss_cnt_d = loss_cnt_q;
    end
  end

  // Lock-loss registers, cleared only by rst
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      loss_cnt_q  <= 8'd0;
      lock_lost_q <= 1'b0;
    end else begin
      loss_cnt_q  <= loss_cnt_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign loss_cnt  = loss_cnt_q;
  assign lock_lost = lock_lost_q;
`else
  // Feature disabled: no lock-loss statistics ports or logic
`endif

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Consumes the PLL `locked` output and produces the design's staged reset releases in the `sys_clk` domain.
- Synchronises and qualifies `locked`, then releases the SDRAM controller reset.
- Waits for the SDRAM init-done handshake, then releases the CPU/peripheral reset after a fixed delay.
- Detects loss of lock and init timeout; on either, the whole system is driven back into reset.

Parameters:
- STABLE_CYCLES, 1024: consecutive cycles the synchronised lock must stay high before `sdr_rst` is released (≥2).
- CPU_DELAY, 16: cycles between `sdr_init_done` and `cpu_rst` release (≥1).
- INIT_TIMEOUT, 65535: maximum cycles in SDR_INIT waiting for `sdr_init_done` before fault.
- CNT_W, 16: width of the shared cycle counter; must hold max(STABLE_CYCLES, CPU_DELAY, INIT_TIMEOUT).

Ports:
- sys_clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL lock, asynchronous to `sys_clk`.
- sdr_init_done  in  1  level from SDRAM controller; 1 = init sequence complete.
- sdr_rst  out  1  active-high reset to the SDRAM controller.
- cpu_rst  out  1  active-high reset to CPU, PIT and peripherals.
- ready  out  1  1 only in RUN.
- fault  out  1  sticky init-timeout flag.
- state  out  3  current FSM state encoding, for debug.

Behaviour:
- **Synchroniser:** two-flop synchroniser `pll_locked` → `lk_s`. `lk_s` reflects an input sampled at edge k on edge k+1.
- **Register outputs:** all outputs are registered and decoded from the next state, so they change on the same edge as `state`.
- **Reset (`rst`=1):** state=HOLD(0), counter=0, sync flops=0, sdr_rst=1, cpu_rst=1, ready=0, fault=0. `rst` overrides everything, including FAULT.
- **States:** HOLD=0, WAIT_LOCK=1, SETTLE=2, SDR_INIT=3, CPU_DLY=4, RUN=5, FAULT=6.
- **HOLD:** unconditionally → WAIT_LOCK on the next cycle.
- **WAIT_LOCK:** if lk_s=1 → SETTLE, counter cleared.
- **SETTLE:**
  - Counter increments each cycle.
  - If lk_s=0 → WAIT_LOCK.
  - If counter==STABLE_CYCLES-1 with lk_s=1 → SDR_INIT, counter cleared.
  - SETTLE therefore lasts exactly STABLE_CYCLES cycles.
- **SDR_INIT:**
  - sdr_rst=0, cpu_rst=1.
  - If sdr_init_done=1 → CPU_DLY, counter cleared.
  - Else if counter==INIT_TIMEOUT-1 → FAULT.
  - If both hold in the same cycle, sdr_init_done wins.
- **CPU_DLY:** sdr_rst=0, cpu_rst=1; counter increments; if counter==CPU_DELAY-1 → RUN.
- **RUN:** sdr_rst=0, cpu_rst=0, ready=1.
- **FAULT:** sdr_rst=1, cpu_rst=1, fault=1. Stays in FAULT until `rst`; lock changes are ignored.
- **Lock loss:**
  - In SETTLE, SDR_INIT, CPU_DLY or RUN, lk_s=0 → WAIT_LOCK.
  - sdr_rst=1, cpu_rst=1, ready=0 on that same edge.
  - Lock loss has priority over every other transition in these states.
- **Mid-sequence drop of sdr_init_done:** no effect after leaving SDR_INIT.
- **Counter:** saturating, never wraps.
- **Latency:** pll_locked first sampled 1 at edge k and held → SETTLE at k+2, sdr_rst falls at k+2+STABLE_CYCLES.

Optional Feature:
- **Macro:** PLL_RESET_SEQ_LOSS_CNT_EN.
- **When defined:**
  - Adds output `loss_cnt[7:0]`, which counts lock-loss transitions out of SETTLE/SDR_INIT/CPU_DLY/RUN.
  - Saturates at 255; cleared only by `rst`.
  - Adds output `lock_lost` as a one-cycle pulse on each counted event.
- **When undefined:** neither port exists and the core FSM behaviour is identical.

Test Plan (all with STABLE_CYCLES=8, CPU_DELAY=4, INIT_TIMEOUT=20):
- **Power-up:** rst high 3 cycles, pll_locked=0 → sdr_rst=1, cpu_rst=1, ready=0, state=1 after rst release.
- **Normal sequence:** pll_locked rises, first sampled at edge 10 → state=2 at edge 12, sdr_rst=0 at edge 20. sdr_init_done=1 at edge 25 → CPU_DLY at edge 26, cpu_rst=0 and ready=1 at edge 30.
- **Glitchy lock:** pll_locked high 5 cycles then low 1 → returns to WAIT_LOCK, sdr_rst never deasserts; re-lock restarts the full 8-cycle count.
- **Init timeout:** sdr_init_done held 0 → fault=1, state=6, sdr_rst=1 exactly 20 cycles after SDR_INIT entry. Subsequent lock toggles produce no change; rst clears fault.
- **Lock loss in RUN:** pll_locked drops → two cycles later sdr_rst=1, cpu_rst=1, ready=0, state=1. With PLL_RESET_SEQ_LOSS_CNT_EN, loss_cnt=1 and lock_lost pulses once.
- **Simultaneous done and timeout:** sdr_init_done=1 on counter==19 → CPU_DLY, fault stays 0.
